calc_req_driver: RTL

Request-side initiator for one `calc_top` request port; one instance per port, four per system. It accepts a local operation through a valid/ready handshake and serialises it onto the port's `req*_cmd_in`/`req*_data_in` pins as a command+operand1 cycle followed by an operand2 cycle. It then watches the paired `out_resp*`/`out_data*` pins for the response, with a timeout, and returns the result to the client through a second valid/ready handshake. Only one operation is outstanding at a time, matching the calc port protocol.

---
 rtl/calc_req_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/calc_req_driver.sv
// Request-side initiator for one calc_top port: serialises a client op into
// cmd+data1 / data2 cycles, waits for the response with a timeout, returns it.
module calc_req_driver #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_resp,
    output logic [31:0] res_data,
    output logic        res_timeout,
    output logic [7:0]  res_cycles,
    output logic        err_unexp
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_DATA2 = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [2:0]  state;
    logic [31:0] data2_q;
    logic [7:0]  cnt;
    logic        resp_seen;
    logic        in_window;

    assign resp_seen = (out_resp != 2'd0);
    assign in_window = (state == S_DATA2) || (state == S_WAIT);

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            data2_q      <= '0;
            cnt          <= '0;
            op_ready     <= 1'b0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            res_valid    <= 1'b0;
            res_resp     <= '0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
            res_cycles   <= '0;
            err_unexp    <= 1'b0;
        end else begin
            // Responses outside the DATA2/WAIT window only raise the sticky flag.
            if (resp_seen && !in_window)
                err_unexp <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (op_valid && op_ready) begin
                        data2_q  <= op_data2;
                        op_ready <= 1'b0;
                        if (op_cmd != 4'd0) begin
                            state        <= S_CMD;
                            req_cmd_out  <= op_cmd;
                            req_data_out <= op_data1;
                        end else begin
                            state     <= S_DONE;
                            res_valid <= 1'b1;
                        end
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                S_CMD: begin
                    state        <= S_DATA2;
                    req_cmd_out  <= '0;
                    req_data_out <= data2_q;
                    cnt          <= 8'd1;
                end
                S_DATA2, S_WAIT: begin
                    req_data_out <= '0;
                    if (resp_seen) begin
                        state      <= S_DONE;
                        res_valid  <= 1'b1;
                        res_resp   <= out_resp;
                        res_data   <= out_data;
                        res_cycles <= cnt;
                    end else if (cnt == TMO) begin
                        state       <= S_DONE;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                        res_cycles  <= TMO;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state       <= S_IDLE;
                        op_ready    <= 1'b1;
                        res_valid   <= 1'b0;
                        res_resp    <= '0;
                        res_data    <= '0;
                        res_timeout <= 1'b0;
                        res_cycles  <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    op_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
